// File: rtl/onehot_rr_arbiter_pkg.sv
// rtl/onehot_rr_arbiter_pkg.sv - shared parameters and helpers for the round-robin request stage
//
// Purpose : default line count, pointer-width derivation and a one-hot to
//           index helper for checkers and monitors.
// Ports   : none (package).

package onehot_rr_arbiter_pkg;

  // Eight lines feed the downstream 8-to-3 encoder.
  localparam int N_DEF = 8;

  // Width of the round-robin pointer for a given line count.
  function automatic int ptr_width(input int n);
    return $clog2(n);
  endfunction

  // Index of the highest set bit; zero for an all-zero word.
  // Callers pass legal one-hot words, so "highest" is simply "the" bit.
  function automatic logic [4:0] onehot_to_idx(input logic [31:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = 5'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_rr_arbiter_rr_pick.sv
// rtl/onehot_rr_arbiter_rr_pick.sv - combinational round-robin find-first over pending bits
//
// Purpose : pick the first set bit of i_pending searching upward from i_ptr,
//           wrapping from N-1 to 0.
// Ports   : i_pending [N]  candidate bits
//           i_ptr     [IW] search start index
//           o_grant   [N]  one-hot of the chosen bit (zero when none)
//           o_idx     [IW] index of the chosen bit
//           o_any     [1]  at least one candidate present

module onehot_rr_arbiter_rr_pick
  import onehot_rr_arbiter_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = ptr_width(N)
) (
  input  logic [N-1:0]  i_pending,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [N-1:0]  w_rot;
  logic [IW-1:0] w_first;
  logic          w_found;

  always_comb begin
    // Rotate right by ptr so the search start lands at bit 0.
    w_rot   = N'({i_pending, i_pending} >> i_ptr);
    w_first = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_first = IW'(k);
        w_found = 1'b1;
      end
    end
    // N is a power of two, so IW-bit addition is the modulo-N rotate back.
    o_idx   = w_first + i_ptr;
    o_any   = w_found;
    o_grant = w_found ? (N'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// rtl/onehot_rr_arbiter.sv - edge-captured request lines presented round-robin as one-hot events
//
// Purpose : capture rising edges on N request lines into a pending register
//           and present them one at a time, round-robin, as a registered
//           one-hot word with a valid/ready handshake.
// Ports   : clk        [1] clock, rising edge
//           rst        [1] synchronous active-high reset
//           req_in     [N] synchronised level requests
//           out_onehot [N] registered one-hot event, zero when out_valid=0
//           out_valid  [1] out_onehot holds an event
//           out_ready  [1] consumer accepts the event this cycle
//           pending    [N] captured, not yet presented events
//           drop       [1] one-cycle pulse: a rise merged into a pending line

module onehot_rr_arbiter
  import onehot_rr_arbiter_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  output logic [N-1:0] out_onehot,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         drop
);

  localparam int IW = ptr_width(N);

  logic [N-1:0]  r_req_q;
  logic [N-1:0]  r_pending;
  logic [IW-1:0] r_ptr;
  logic [N-1:0]  r_onehot;
  logic          r_valid;
  logic          r_drop;

  logic [N-1:0]  w_rise;
  logic          w_load;
  logic [N-1:0]  w_grant;
  logic [IW-1:0] w_idx;
  logic          w_any;
  logic [N-1:0]  w_clr;

  onehot_rr_arbiter_rr_pick #(.N(N), .IW(IW)) u_pick (
    .i_pending (r_pending),
    .i_ptr     (r_ptr),
    .o_grant   (w_grant),
    .o_idx     (w_idx),
    .o_any     (w_any)
  );

  assign w_rise = req_in & ~r_req_q;
  assign w_load = ~r_valid | out_ready;
  // Only the bit actually moved into the output register leaves pending.
  assign w_clr  = (w_load && w_any) ? w_grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_q   <= '0;
      r_pending <= '0;
      r_ptr     <= '0;
      r_onehot  <= '0;
      r_valid   <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_req_q   <= req_in;
      // Set wins over clear: a rise on the line granted this edge is a new event.
      r_pending <= (r_pending & ~w_clr) | w_rise;
      r_drop    <= |(w_rise & r_pending & ~w_clr);
      if (w_load) begin
        if (w_any) begin
          r_onehot <= w_grant;
          r_valid  <= 1'b1;
          r_ptr    <= w_idx + IW'(1);
        end else begin
          r_onehot <= '0;
          r_valid  <= 1'b0;
        end
      end
    end
  end

  assign out_onehot = r_onehot;
  assign out_valid  = r_valid;
  assign pending    = r_pending;
  assign drop       = r_drop;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// tb/tb_onehot_rr_arbiter.sv - directed self-checking bench for onehot_rr_arbiter

module tb_onehot_rr_arbiter;
  import onehot_rr_arbiter_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] out_onehot;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pending;
  logic       drop;

  int errors = 0;
  int checks = 0;
  int acc[8];
  bit drop_seen;
  int snap;

  onehot_rr_arbiter #(.N(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req_in),
    .out_onehot (out_onehot),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pending    (pending),
    .drop       (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted events per line, counted at the handshake edge.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) acc[onehot_to_idx({24'd0, out_onehot})]++;
    if (!rst && drop) drop_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("inv_onehot0", {31'd0, $onehot0(out_onehot)}, 32'd1);
    chk("inv_valid_vs_onehot", {31'd0, out_valid}, {31'd0, (out_onehot != 8'h00)});
  endtask

  task automatic out_is(input string tag, input logic [7:0] oh, input logic v);
    chk({tag, "_onehot"}, {24'd0, out_onehot}, {24'd0, oh});
    chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
  endtask

  initial begin
    for (int i = 0; i < 8; i++) acc[i] = 0;
    drop_seen = 1'b0;
    rst = 1'b1; req_in = 8'h00; out_ready = 1'b1;
    tick(); tick();
    out_is("reset", 8'h00, 1'b0);
    chk("reset_pending", {24'd0, pending}, 32'h0);
    chk("reset_drop", {31'd0, drop}, 32'd0);
    chk("reset_ptr", {29'd0, dut.r_ptr}, 32'd0);
    rst = 1'b0;

    // 1: single rise on line 5
    req_in = 8'h20; tick();
    chk("t1_pending_e0", {24'd0, pending}, 32'h20);
    out_is("t1_e0", 8'h00, 1'b0);
    tick();
    out_is("t1_e1", 8'h20, 1'b1);
    chk("t1_pending_e1", {24'd0, pending}, 32'h0);
    chk("t1_ptr", {29'd0, dut.r_ptr}, 32'd6);
    tick();
    out_is("t1_e2", 8'h00, 1'b0);

    // 2: three simultaneous rises from reset
    rst = 1'b1; req_in = 8'h00; tick(); rst = 1'b0;
    req_in = 8'h4A; tick();
    chk("t2_pending", {24'd0, pending}, 32'h4A);
    tick(); out_is("t2_g0", 8'h02, 1'b1);
    tick(); out_is("t2_g1", 8'h08, 1'b1);
    tick(); out_is("t2_g2", 8'h40, 1'b1);
    chk("t2_ptr", {29'd0, dut.r_ptr}, 32'd7);
    tick(); out_is("t2_idle", 8'h00, 1'b0);

    // 3: wrap from ptr=7
    req_in = 8'h81; tick();
    chk("t3_pending", {24'd0, pending}, 32'h81);
    tick(); out_is("t3_g0", 8'h80, 1'b1);
    tick(); out_is("t3_g1", 8'h01, 1'b1);
    chk("t3_ptr", {29'd0, dut.r_ptr}, 32'd1);
    tick(); out_is("t3_idle", 8'h00, 1'b0);

    // 4: backpressure and drop
    req_in = 8'h00; tick();
    snap = acc[2];
    out_ready = 1'b0; req_in = 8'h04; tick();
    chk("t4_pending0", {24'd0, pending}, 32'h04);
    tick(); out_is("t4_grant", 8'h04, 1'b1);
    chk("t4_pending1", {24'd0, pending}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick(); out_is("t4_hold", 8'h04, 1'b1);
    end
    req_in = 8'h00; tick();
    req_in = 8'h04; tick();
    chk("t4_rise_pending", {24'd0, pending}, 32'h04);
    chk("t4_rise_drop", {31'd0, drop}, 32'd0);
    req_in = 8'h00; tick();
    chk("t4_low_drop", {31'd0, drop}, 32'd0);
    req_in = 8'h04; tick();
    chk("t4_merge_drop", {31'd0, drop}, 32'd1);
    chk("t4_merge_pending", {24'd0, pending}, 32'h04);
    out_is("t4_merge_out", 8'h04, 1'b1);
    tick();
    chk("t4_drop_pulse_end", {31'd0, drop}, 32'd0);
    out_ready = 1'b1; tick();
    out_is("t4_second", 8'h04, 1'b1);
    chk("t4_pending2", {24'd0, pending}, 32'h0);
    tick(); out_is("t4_idle", 8'h00, 1'b0);
    tick();
    chk("t4_accepts", acc[2] - snap, 32'd2);

    // 5: level held high produces one event
    req_in = 8'h00; tick();
    drop_seen = 1'b0; snap = acc[4];
    req_in = 8'h10;
    for (int i = 0; i < 10; i++) tick();
    req_in = 8'h00; tick(); tick();
    chk("t5_accepts", acc[4] - snap, 32'd1);
    chk("t5_no_drop", {31'd0, drop_seen}, 32'd0);
    chk("t5_ptr", {29'd0, dut.r_ptr}, 32'd5);

    // 6: reset mid-operation
    out_ready = 1'b0; req_in = 8'h02; tick();
    tick(); out_is("t6_held", 8'h02, 1'b1);
    req_in = 8'h00; tick();
    req_in = 8'h55; tick();
    chk("t6_pending", {24'd0, pending}, 32'h55);
    out_is("t6_pre", 8'h02, 1'b1);
    req_in = 8'h00; rst = 1'b1; tick();
    rst = 1'b0;
    out_is("t6_rst", 8'h00, 1'b0);
    chk("t6_rst_pending", {24'd0, pending}, 32'h0);
    chk("t6_rst_ptr", {29'd0, dut.r_ptr}, 32'd0);
    chk("t6_rst_drop", {31'd0, drop}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); out_is("t6_quiet", 8'h00, 1'b0);
    end
    chk("t6_quiet_pending", {24'd0, pending}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
